// File: rtl/sine_phase_stepper_pkg.sv
// Shared constants and elaboration-time helpers for the phase-accumulator sine source.
package sine_phase_stepper_pkg;

    localparam int          SINE_ACC_W        = 24;
    localparam int          SINE_LUT_AW       = 8;
    localparam int          SINE_DATA_W       = 12;
    localparam logic [31:0] SINE_STEP_DEFAULT = 32'h0000_4000;
    localparam logic [15:0] LFSR_SEED         = 16'hACE1;

    // pi/2 in Q30, used by the integer sine series below
    localparam longint PI_HALF_Q30 = 64'sd1686629713;

    function automatic longint step_from_freq(longint fs, longint fout, int accw);
        return (fout << accw) / fs;
    endfunction

    function automatic int dither_width(int acc_w, int lut_aw);
        return ((acc_w - 2 - lut_aw) < 16) ? (acc_w - 2 - lut_aw) : 16;
    endfunction

    // round((2^(dw-1)-1) * sin(pi/2 * (i+0.5) / 2^aw)), Taylor series to x^13 in Q30
    function automatic int quarter_sine(int i, int aw, int dw);
        longint x;
        longint term;
        longint sum;
        longint amp;
        x    = (PI_HALF_Q30 * longint'(2 * i + 1)) >>> (aw + 1);
        term = x;
        sum  = x;
        for (int k = 1; k <= 6; k++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        amp = (longint'(1) <<< (dw - 1)) - longint'(1);
        return int'((sum * amp + (longint'(1) <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/sine_phase_stepper_rom.sv
// Quarter-wave sine ROM with registered read; contents built at elaboration.
module quarter_sine_rom
    import sine_phase_stepper_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int DATA_W = 12
) (
    input  logic              src_clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] rom_table [2**LUT_AW];

    for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_rom
        assign rom_table[g] = DATA_W'(quarter_sine(g, LUT_AW, DATA_W));
    end

    always_ff @(posedge src_clk) begin
        data <= rom_table[addr];
    end

endmodule

// File: rtl/sine_phase_stepper.sv
// Phase-accumulator sine source: one signed sample per tick rising edge, fixed 3-cycle latency.
// Optional phase dither on the ROM address path when PHASE_DITHER_EN is defined.
module sine_phase_stepper
    import sine_phase_stepper_pkg::*;
#(
    parameter int          ACC_W        = SINE_ACC_W,
    parameter int          LUT_AW       = SINE_LUT_AW,
    parameter int          DATA_W       = SINE_DATA_W,
    parameter logic [31:0] STEP_DEFAULT = SINE_STEP_DEFAULT
) (
    input  logic                     src_clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     tick,
    input  logic                     step_load,
    input  logic [ACC_W-1:0]         step_in,
    output logic                     step_ack,
    output logic signed [DATA_W-1:0] sample,
    output logic                     sample_valid,
    output logic                     phase_wrap
);

    localparam int          TOP_W    = LUT_AW + 2;
    localparam logic [ACC_W-1:0] STEP_RST = ACC_W'(STEP_DEFAULT);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  step;
    logic [ACC_W:0]    acc_sum;
    logic              tick_q;
    logic              advance;
    logic [TOP_W-1:0]  p_top;
    logic [TOP_W-1:0]  s1_phase;
    logic              s1_valid;
    logic [1:0]        s1_quad;
    logic [LUT_AW-1:0] s1_idx;
    logic [LUT_AW-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              s2_valid;
    logic [1:0]        s2_quad;

    assign advance = en & tick & ~tick_q;
    assign acc_sum = {1'b0, acc} + {1'b0, step};

`ifdef PHASE_DITHER_EN
    localparam int LOW_W  = ACC_W - 2 - LUT_AW;
    localparam int DITH_W = dither_width(ACC_W, LUT_AW);

    logic [15:0]      lfsr;
    logic             lfsr_fb;
    logic [LOW_W-1:0] dither;
    logic             dith_carry;

    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign dither  = LOW_W'(lfsr[DITH_W-1:0]);
    // carry out of the truncated bits: acc_low + dither >= 2^LOW_W
    assign dith_carry = acc[LOW_W-1:0] > ~dither;
    assign p_top      = acc[ACC_W-1 -: TOP_W] + TOP_W'(dith_carry);

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (advance) begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end
`else
    assign p_top = acc[ACC_W-1 -: TOP_W];
`endif

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            acc        <= '0;
            step       <= STEP_RST;
            tick_q     <= 1'b0;
            s1_valid   <= 1'b0;
            s1_phase   <= '0;
            phase_wrap <= 1'b0;
            step_ack   <= 1'b0;
        end else begin
            tick_q     <= tick;
            step_ack   <= step_load;
            s1_valid   <= advance;
            phase_wrap <= advance & acc_sum[ACC_W];
            if (advance) begin
                s1_phase <= p_top;
                acc      <= acc_sum[ACC_W-1:0];
            end
            // a coincident advance already used the old step above
            if (step_load) begin
                step <= step_in;
            end
        end
    end

    assign s1_quad  = s1_phase[TOP_W-1 -: 2];
    assign s1_idx   = s1_phase[LUT_AW-1:0];
    assign rom_addr = s1_quad[0] ? ~s1_idx : s1_idx;

    quarter_sine_rom #(
        .LUT_AW (LUT_AW),
        .DATA_W (DATA_W)
    ) u_rom (
        .src_clk (src_clk),
        .addr    (rom_addr),
        .data    (rom_data)
    );

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_quad  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_quad  <= s1_quad;
        end
    end

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= s2_valid;
            if (s2_valid) begin
                sample <= s2_quad[1] ? -rom_data : rom_data;
            end
        end
    end

endmodule
